bus_op_sequencer: RTL

Sequences L2 bus operations for the cache simulator: accepts one bus request at a time from the L2 controller, drives address and operation onto the snoop interface, samples the 2-bit snoop result after a fixed wait, and returns that result plus the resulting MESI state for the requesting line. Sits directly upstream of the snoop-result responder and consumes what it drives on `snoopBus`. Also keeps saturating statistics counters for the simulator report.

---
 rtl/cache_bus_pkg.sv | 19 +
 rtl/sat_counter.sv | 16 +
 rtl/bus_op_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/cache_bus_pkg.sv
// cache_bus_pkg: bus op codes, snoop/MESI encodings and next-state rule for the L2 bus sequencer
package cache_bus_pkg;
  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_READ       = 8'h01;
  localparam logic [7:0] OP_WRITE      = 8'h02;
  localparam logic [7:0] OP_INVALIDATE = 8'h03;
  localparam logic [7:0] OP_RWIM       = 8'h04;
  typedef enum logic [1:0] {SNOOP_NOHIT, SNOOP_HIT, SNOOP_HITM, SNOOP_RSVD} snoop_t;
  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_t;
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  function automatic logic op_legal(input logic [7:0] op);
    return op >= OP_READ && op <= OP_RWIM;
  endfunction
  function automatic mesi_t next_mesi(input logic [7:0] op, input logic [1:0] snoop);
    return snoop == SNOOP_RSVD ? MESI_I :
           op == OP_READ ? (snoop == SNOOP_NOHIT ? MESI_E : MESI_S) :
           op == OP_WRITE ? MESI_I : MESI_M;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: statistics counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int counterWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    inc,
  output logic [counterWidth-1:0] count
);
  // count up on inc, hold once saturated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/bus_op_sequencer.sv
// bus_op_sequencer: drives one L2 bus op onto the snoop interface, samples the result, reports MESI state
module bus_op_sequencer
  import cache_bus_pkg::*;
#(
  parameter int addressSize  = 32,
  parameter int snoopWait    = 2,
  parameter int counterWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic [7:0]              reqOp,
  input  logic [addressSize-1:0]  reqAddr,
  output logic [addressSize-1:0]  busAddress,
  output logic [7:0]              busOperation,
  input  logic [1:0]              snoopBus,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [1:0]              rspResult,
  output logic [1:0]              rspNextState,
  output logic                    rspError,
  output logic [counterWidth-1:0] opCount,
  output logic [counterWidth-1:0] hitCount,
  output logic [counterWidth-1:0] hitmCount
);
  localparam int WW = $clog2(snoopWait + 1);
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic accept, sample, legal;
  assign reqReady = state == IDLE;
  assign rspValid = state == RESP;
  assign accept   = reqValid && reqReady;
  assign legal    = op_legal(reqOp);
  assign sample   = state == DRIVE && wait_cnt == WW'(1);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: illegal ops skip the bus entirely
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (accept ? (legal ? DRIVE : RESP) : IDLE) :
               state == DRIVE ? (sample ? RESP : DRIVE) :
               (rspReady ? IDLE : RESP);
  end
  // bus drive, wait countdown and response capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wait_cnt     <= '0;
      busAddress   <= '0;
      busOperation <= OP_NOP;
      rspResult    <= SNOOP_NOHIT;
      rspNextState <= MESI_I;
      rspError     <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt <= WW'(snoopWait);
        if (legal) begin
          busAddress   <= reqAddr;
          busOperation <= reqOp;
        end else begin
          rspResult    <= SNOOP_NOHIT;
          rspNextState <= MESI_I;
          rspError     <= 1'b1;
        end
      end
      if (state == DRIVE) wait_cnt <= wait_cnt - 1'b1;
      if (sample) begin
        busAddress   <= '0;
        busOperation <= OP_NOP;
        rspResult    <= snoopBus;
        rspNextState <= next_mesi(busOperation, snoopBus);
        rspError     <= snoopBus == SNOOP_RSVD;
      end
    end
  sat_counter #(.counterWidth(counterWidth)) u_op (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .inc(sample && snoopBus != SNOOP_RSVD), .count(opCount)
  );
  sat_counter #(.counterWidth(counterWidth)) u_hit (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .inc(sample && snoopBus == SNOOP_HIT), .count(hitCount)
  );
  sat_counter #(.counterWidth(counterWidth)) u_hitm (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .inc(sample && snoopBus == SNOOP_HITM), .count(hitmCount)
  );
endmodule
